io_bank_decoder: RTL and testbench

Parametrised successor to the nano6502 address decoder and CPU read-data mux. It holds the IO-bank, ROM-overlay and per-bank wait-state registers and produces RAM/ROM/register chip selects plus one registered chip select per IO bank for the 0xFE00–0xFEFF page. It merges the previously scattered read-data priority mux into one registered-select mux, and adds a programmable per-bank RDY stall for slow peripherals. It sits between `cpu_65c02` and all bus slaves in `nano6502_top`.

---
 rtl/nano6502_bus_pkg.sv | 30 +++
 rtl/io_bank_decoder_if.sv | 21 ++
 rtl/io_wait_fsm.sv | 61 ++++++
 rtl/io_bank_decoder.sv | 159 +++++++++++++++
 tb/tb_io_bank_decoder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nano6502_bus_pkg.sv
// nano6502 bus constants shared by the IO-bank decoder and its wait FSM.
// Address map anchors, register offsets and read-select encoding.
package nano6502_bus_pkg;

   localparam logic [15:0] REG_BASE = 16'h0000;
   localparam logic [7:0]  IO_PAGE  = 8'hFE;
   localparam logic [7:0]  VEC_PAGE = 8'hFF;
   localparam logic [15:0] ROM_LO   = 16'hE000;

   localparam logic [1:0] OFS_BANK_L  = 2'd0;
   localparam logic [1:0] OFS_BANK_H  = 2'd1;
   localparam logic [1:0] OFS_ROM_CTL = 2'd2;
   localparam logic [1:0] OFS_WAIT    = 2'd3;

   localparam int ROM_CTL_BIT = 0;

   typedef enum logic [2:0] {
      SEL_FF,
      SEL_RAM,
      SEL_ROM,
      SEL_BANK,
      SEL_REG
   } rd_sel_t;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } wait_st_t;

endpackage

// File: rtl/io_bank_decoder_if.sv
// CPU-side bus of the IO-bank decoder: address, write data and strobe
// from the 65C02, RDY and read data back to it.
interface io_bank_decoder_if;

   logic [15:0] addr;
   logic        we;
   logic [7:0]  data;
   logic        rdy;
   logic [7:0]  cpu_data;

   modport master (
      output addr, we, data,
      input  rdy, cpu_data
   );

   modport slave (
      input  addr, we, data,
      output rdy, cpu_data
   );

endinterface

// File: rtl/io_wait_fsm.sv
// Per-access RDY stall generator for slow IO banks.
// The wait count is captured at access start; later register writes do not disturb it.
module io_wait_fsm
   import nano6502_bus_pkg::*;
#(
   parameter int WAIT_W = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [WAIT_W-1:0] wait_i,
   output logic              rdy_o,
   output logic              last_o,
   output logic              busy_o
);

   localparam int CNT_W = (WAIT_W < 3) ? 3 : WAIT_W;

   wait_st_t         st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // state and remaining-stall counter
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         st_q  <= ST_IDLE;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end
   end

   // next state and RDY: a stall of w cycles holds RDY low for exactly w cycles
   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      rdy_o = 1'b1;
      unique case (st_q)
         ST_IDLE: begin
            if (start_i && (wait_i != '0)) begin
               rdy_o = 1'b0;
               st_d  = ST_WAIT;
               cnt_d = CNT_W'(wait_i) - CNT_W'(1);
            end
         end
         ST_WAIT: begin
            rdy_o = (cnt_q == '0);
            if (cnt_q == '0) begin
               st_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   assign last_o = rdy_o;
   assign busy_o = (st_q == ST_WAIT);

endmodule

// File: rtl/io_bank_decoder.sv
// nano6502 address decoder: bank/ROM/wait registers, chip selects,
// registered IO-bank strobes and the registered-select CPU read mux.
module io_bank_decoder
   import nano6502_bus_pkg::*;
#(
   parameter int NUM_BANKS    = 8,
   parameter int WAIT_W       = 3,
   parameter int DEFAULT_WAIT = 0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   io_bank_decoder_if.slave       cpu,
   output logic                   ram_cs_o,
   output logic                   ram_we_o,
   output logic                   rom_cs_o,
   output logic [NUM_BANKS-1:0]   bank_cs_o,
   output logic                   bank_wr_o,
   input  logic [7:0]             ram_data_i,
   input  logic [7:0]             rom_data_i,
   input  logic [8*NUM_BANKS-1:0] bank_data_i
);

   localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   logic [15:0]       bank_q;
   logic              rom_ctl_q;
   logic [WAIT_W-1:0] wait_q [NUM_BANKS];
   logic [BW-1:0]     acc_bank_q;
   rd_sel_t           sel_q;
   logic [BW-1:0]     sel_bank_q;
   logic [7:0]        reg_rd_q;

   logic          is_reg, is_io, is_vec, in_win;
   logic          bank_ok, io_hit, rom_rd, ram_sel;
   logic          rdy, last, busy, start;
   logic [BW-1:0] cur_bank, io_bank;
   logic [7:0]    reg_val;
   rd_sel_t       sel_d;

   assign cur_bank = bank_q[BW-1:0];
   assign bank_ok  = (bank_q < 16'(NUM_BANKS));
   // an access already stalling keeps the bank it started with
   assign io_bank  = busy ? acc_bank_q : cur_bank;

   assign is_reg  = (cpu.addr[15:2] == REG_BASE[15:2]);
   assign is_io   = (cpu.addr[15:8] == IO_PAGE);
   assign is_vec  = (cpu.addr[15:8] == VEC_PAGE);
   assign in_win  = (cpu.addr >= ROM_LO) && !is_io && !is_vec
                    && !rom_ctl_q;
   assign io_hit  = is_io && (busy || bank_ok);
   assign rom_rd  = !cpu.we && (is_vec || in_win);
   assign ram_sel = !is_reg && !is_io && !rom_rd;

   assign start = is_io && bank_ok;

   io_wait_fsm #(.WAIT_W(WAIT_W)) u_wait (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start),
      .wait_i  (wait_q[cur_bank]),
      .rdy_o   (rdy),
      .last_o  (last),
      .busy_o  (busy)
   );

   assign cpu.rdy  = rdy;
   assign ram_cs_o = ram_sel && !rst_i;
   assign rom_cs_o = rom_rd && !rst_i;
   assign ram_we_o = ram_cs_o && cpu.we && rdy;

   // register read value for the current address
   always_comb begin
      reg_val = 8'h00;
      unique case (cpu.addr[1:0])
         OFS_BANK_L:  reg_val = bank_q[7:0];
         OFS_BANK_H:  reg_val = bank_q[15:8];
         OFS_ROM_CTL: reg_val = {7'd0, rom_ctl_q};
         OFS_WAIT:    reg_val = bank_ok ? 8'(wait_q[cur_bank]) : 8'h00;
         default:     reg_val = 8'h00;
      endcase
   end

   // read source chosen by the decode priority
   always_comb begin
      sel_d = SEL_RAM;
      if (is_reg) begin
         sel_d = SEL_REG;
      end else if (is_io) begin
         sel_d = io_hit ? SEL_BANK : SEL_FF;
      end else if (rom_rd) begin
         sel_d = SEL_ROM;
      end
   end

   // zero-page control registers; writes never reach RAM
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bank_q    <= 16'h0000;
         rom_ctl_q <= 1'b0;
         for (int k = 0; k < NUM_BANKS; k++) begin
            wait_q[k] <= WAIT_W'(DEFAULT_WAIT);
         end
      end else if (is_reg && cpu.we && rdy) begin
         unique case (cpu.addr[1:0])
            OFS_BANK_L:  bank_q[7:0]  <= cpu.data;
            OFS_BANK_H:  bank_q[15:8] <= cpu.data;
            OFS_ROM_CTL: rom_ctl_q    <= cpu.data[ROM_CTL_BIT];
            OFS_WAIT: begin
               if (bank_ok) begin
                  wait_q[cur_bank] <= cpu.data[WAIT_W-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   // remember the bank of an access while it is not stalled
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_bank_q <= '0;
      end else if (!busy) begin
         acc_bank_q <= cur_bank;
      end
   end

   // strobes and read select, captured only on the final cycle of an access
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bank_cs_o  <= '0;
         bank_wr_o  <= 1'b0;
         sel_q      <= SEL_FF;
         sel_bank_q <= '0;
         reg_rd_q   <= 8'hFF;
      end else if (last) begin
         bank_cs_o  <= io_hit ? (NUM_BANKS'(1) << io_bank) : '0;
         bank_wr_o  <= io_hit && cpu.we;
         sel_q      <= sel_d;
         sel_bank_q <= io_bank;
         reg_rd_q   <= reg_val;
      end else begin
         bank_cs_o <= '0;
         bank_wr_o <= 1'b0;
      end
   end

   // CPU read data from the registered select
   always_comb begin
      cpu.cpu_data = 8'hFF;
      unique case (sel_q)
         SEL_RAM:  cpu.cpu_data = ram_data_i;
         SEL_ROM:  cpu.cpu_data = rom_data_i;
         SEL_BANK: cpu.cpu_data = bank_data_i[8*sel_bank_q +: 8];
         SEL_REG:  cpu.cpu_data = reg_rd_q;
         default:  cpu.cpu_data = 8'hFF;
      endcase
   end

endmodule

// File: tb/tb_io_bank_decoder.sv
// Bench for io_bank_decoder: transaction-level model of the address map,
// registers and stall lengths, compared against the DUT on every cycle.
module tb_io_bank_decoder;

   localparam int NB = 8;
   localparam logic [7:0] RAM_V = 8'h3C;
   localparam logic [7:0] ROM_V = 8'hA7;

   logic         clk = 1'b0;
   logic         rst;
   logic         ram_cs, ram_we, rom_cs, bank_wr;
   logic [NB-1:0] bank_cs;
   logic [7:0]   ram_data, rom_data;
   logic [8*NB-1:0] bank_data;

   io_bank_decoder_if cpu_if ();

   io_bank_decoder #(.NUM_BANKS(NB), .WAIT_W(3), .DEFAULT_WAIT(0)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cpu         (cpu_if),
      .ram_cs_o    (ram_cs),
      .ram_we_o    (ram_we),
      .rom_cs_o    (rom_cs),
      .bank_cs_o   (bank_cs),
      .bank_wr_o   (bank_wr),
      .ram_data_i  (ram_data),
      .rom_data_i  (rom_data),
      .bank_data_i (bank_data)
   );

   always #5 clk = ~clk;

   int unsigned n_chk = 0;
   int unsigned n_fail = 0;
   int unsigned lo_total = 0;
   logic check_en = 1'b0;

   // model state
   logic [15:0] m_bank;
   logic        m_rom;
   logic [2:0]  m_wait [NB];

   // expectations for the current cycle
   logic e_rdy, e_ram_cs, e_rom_cs, e_ram_we, e_wr, e_dv;
   logic [NB-1:0] e_cs;
   logic [7:0] e_data;
   // result of the previous access, visible one cycle after its last cycle
   logic p_wr, p_dv;
   logic [NB-1:0] p_cs;
   logic [7:0] p_data;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   task automatic model_reset();
      m_bank = 16'h0000;
      m_rom  = 1'b0;
      for (int k = 0; k < NB; k++) m_wait[k] = 3'd0;
      p_cs = '0; p_wr = 1'b0; p_data = 8'hFF; p_dv = 1'b1;
   endtask

   // one CPU access; called just after a rising edge
   task automatic access(input logic [15:0] a, input logic w,
                         input logic [7:0] d);
      int kind; // 0 reg, 1 io, 2 rom read, 3 ram
      int st;
      logic ok;
      logic [7:0] rv;
      ok = (m_bank < NB);
      if (a <= 16'h0003) kind = 0;
      else if (a >= 16'hFE00 && a <= 16'hFEFF) kind = 1;
      else if (a >= 16'hFF00) kind = w ? 3 : 2;
      else if (a >= 16'hE000 && !m_rom) kind = w ? 3 : 2;
      else kind = 3;
      st = (kind == 1 && ok) ? int'(m_wait[m_bank]) : 0;
      for (int i = 0; i <= st; i++) begin
         cpu_if.addr = a; cpu_if.we = w; cpu_if.data = d;
         e_rdy    = (i == st);
         e_ram_cs = (kind == 3);
         e_rom_cs = (kind == 2);
         e_ram_we = (kind == 3) && w && (i == st);
         e_cs     = (i == 0) ? p_cs : '0;
         e_wr     = (i == 0) ? p_wr : 1'b0;
         e_data   = p_data;
         e_dv     = p_dv;
         @(posedge clk); #1;
      end
      rv = 8'hFF;
      case (kind)
         0: begin
            case (a[1:0])
               2'd0: rv = m_bank[7:0];
               2'd1: rv = m_bank[15:8];
               2'd2: rv = {7'd0, m_rom};
               default: rv = ok ? {5'd0, m_wait[m_bank]} : 8'h00;
            endcase
         end
         1: rv = ok ? 8'h10 + m_bank[7:0] : 8'hFF;
         2: rv = ROM_V;
         default: rv = RAM_V;
      endcase
      p_cs = (kind == 1 && ok) ? NB'(1) << m_bank : '0;
      p_wr = (kind == 1) && ok && w;
      p_dv = !w;
      p_data = rv;
      if (kind == 0 && w) begin
         case (a[1:0])
            2'd0: m_bank[7:0] = d;
            2'd1: m_bank[15:8] = d;
            2'd2: m_rom = d[0];
            default: if (ok) m_wait[m_bank] = d[2:0];
         endcase
      end
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (check_en) begin
         chk("rdy", 32'(cpu_if.rdy), 32'(e_rdy));
         chk("ram_cs", 32'(ram_cs), 32'(e_ram_cs));
         chk("rom_cs", 32'(rom_cs), 32'(e_rom_cs));
         chk("ram_we", 32'(ram_we), 32'(e_ram_we));
         chk("bank_cs", 32'(bank_cs), 32'(e_cs));
         chk("bank_wr", 32'(bank_wr), 32'(e_wr));
         if (e_dv) chk("cpu_data", 32'(cpu_if.cpu_data), 32'(e_data));
         if (!cpu_if.rdy) lo_total++;
      end
   end

   int unsigned lo0;

   initial begin
      ram_data = RAM_V;
      rom_data = ROM_V;
      for (int k = 0; k < NB; k++) bank_data[8*k +: 8] = 8'h10 + 8'(k);
      cpu_if.addr = 16'h0200; cpu_if.we = 1'b0; cpu_if.data = 8'h00;
      rst = 1'b1;
      model_reset();
      #12;
      chk("rst_rdy", 32'(cpu_if.rdy), 32'd1);
      chk("rst_bank_cs", 32'(bank_cs), 32'd0);
      chk("rst_bank_wr", 32'(bank_wr), 32'd0);
      chk("rst_cpu_data", 32'(cpu_if.cpu_data), 32'hFF);
      chk("rst_ram_cs", 32'(ram_cs), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check_en = 1'b1;

      // vector read from ROM
      lo0 = lo_total;
      access(16'hFFFC, 1'b0, 8'h00);
      chk("vec_data", 32'(cpu_if.cpu_data), 32'hA7);
      chk("vec_nostall", lo_total - lo0, 32'd0);

      // bank 4 select and IO read
      access(16'h0000, 1'b1, 8'h04);
      access(16'hFE10, 1'b0, 8'h00);
      chk("b4_cs", 32'(bank_cs), 32'h10);
      chk("b4_data", 32'(cpu_if.cpu_data), 32'h14);
      access(16'h0000, 1'b0, 8'h00);
      chk("bankl_rd", 32'(cpu_if.cpu_data), 32'h04);

      // bank 3 with 3 wait states
      access(16'h0000, 1'b1, 8'h03);
      access(16'h0003, 1'b1, 8'h03);
      access(16'h0003, 1'b0, 8'h00);
      chk("wait_rd", 32'(cpu_if.cpu_data), 32'h03);
      lo0 = lo_total;
      access(16'hFE01, 1'b1, 8'hA5);
      chk("w3_stall", lo_total - lo0, 32'd3);
      chk("w3_cs", 32'(bank_cs), 32'h08);
      chk("w3_wr", 32'(bank_wr), 32'd1);
      access(16'h0200, 1'b0, 8'h00);

      // ROM overlay control
      access(16'h0002, 1'b1, 8'h01);
      access(16'hE123, 1'b1, 8'h55);
      access(16'hE123, 1'b0, 8'h00);
      chk("ovl_ram", 32'(cpu_if.cpu_data), 32'h3C);
      access(16'hFF00, 1'b0, 8'h00);
      chk("ff00_rom", 32'(cpu_if.cpu_data), 32'hA7);
      access(16'h0002, 1'b1, 8'h00);
      access(16'hE123, 1'b0, 8'h00);
      chk("ovl_rom", 32'(cpu_if.cpu_data), 32'hA7);
      access(16'hFDFF, 1'b0, 8'h00);
      access(16'hDFFF, 1'b0, 8'h00);
      chk("below_win", 32'(cpu_if.cpu_data), 32'h3C);

      // bank out of range
      access(16'h0000, 1'b1, 8'h00);
      access(16'h0001, 1'b1, 8'h01);
      lo0 = lo_total;
      access(16'hFE00, 1'b0, 8'h00);
      chk("oor_data", 32'(cpu_if.cpu_data), 32'hFF);
      chk("oor_cs", 32'(bank_cs), 32'd0);
      chk("oor_nostall", lo_total - lo0, 32'd0);
      access(16'hFE00, 1'b1, 8'h77);
      access(16'h0003, 1'b1, 8'h07);
      access(16'h0003, 1'b0, 8'h00);
      chk("oor_wait_rd", 32'(cpu_if.cpu_data), 32'h00);

      // maximum wait count on bank 7
      access(16'h0001, 1'b1, 8'h00);
      access(16'h0000, 1'b1, 8'h07);
      access(16'h0003, 1'b1, 8'h07);
      lo0 = lo_total;
      access(16'hFE20, 1'b0, 8'h00);
      chk("w7_stall", lo_total - lo0, 32'd7);
      chk("w7_data", 32'(cpu_if.cpu_data), 32'h17);

      // reset during the second stall cycle of a wait-5 access
      access(16'h0000, 1'b1, 8'h05);
      access(16'h0003, 1'b1, 8'h05);
      check_en = 1'b0;
      cpu_if.addr = 16'hFE00; cpu_if.we = 1'b0;
      @(posedge clk); #1;
      chk("mid_stall_rdy", 32'(cpu_if.rdy), 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("arst_rdy", 32'(cpu_if.rdy), 32'd1);
      chk("arst_cs", 32'(bank_cs), 32'd0);
      chk("arst_data", 32'(cpu_if.cpu_data), 32'hFF);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      check_en = 1'b1;
      access(16'h0000, 1'b1, 8'h05);
      access(16'h0003, 1'b0, 8'h00);
      chk("arst_wait5", 32'(cpu_if.cpu_data), 32'h00);
      lo0 = lo_total;
      access(16'hFE00, 1'b0, 8'h00);
      chk("arst_nostall", lo_total - lo0, 32'd0);
      chk("arst_b5", 32'(cpu_if.cpu_data), 32'h15);
      check_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
